// File: rtl/traffic_light_monitor_if.sv
// Bundle between the upstream traffic-light FSM / lamp driver and the monitor.
`timescale 1ns/1ps
interface traffic_light_monitor_if;
  localparam int unsigned CNT_W = 16;

  logic [2:0]       lights;
  logic             clear_fault;
  logic [2:0]       lamp_out;
  logic             fault;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_count;

  modport master (output lights, clear_fault,
                  input  lamp_out, fault, err_code, cycle_count);
  modport slave  (input  lights, clear_fault,
                  output lamp_out, fault, err_code, cycle_count);
endinterface

// File: rtl/traffic_light_monitor.sv
// Watches an RYG light stream for bad encodings, bad sequencing and short dwells;
// forwards legal lamps with one cycle of lag and flashes red while faulted.
`timescale 1ns/1ps
module traffic_light_monitor #(
  parameter int unsigned MIN_RED    = 4,
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned FLASH_HALF = 3
) (
  input logic                    clk,
  input logic                    reset,
  traffic_light_monitor_if.slave bus
);
  localparam int unsigned CW = 16;
  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ENC   = 2'b01;
  localparam logic [1:0] ERR_TRANS = 2'b10;
  localparam logic [1:0] ERR_DWELL = 2'b11;
  // A zero half-period behaves as one cycle per phase.
  localparam logic [CW-1:0] HALF_LAST = (FLASH_HALF == 0) ? CW'(0) : CW'(FLASH_HALF - 1);
  localparam logic [CW-1:0] DWELL_MAX = '1;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

  state_t        state;
  logic [2:0]    lights_q;
  logic [2:0]    lamp_q;
  logic [CW-1:0] dwell_q;
  logic [CW-1:0] flash_q;
  logic [CW-1:0] cycle_q;
  logic          first_seg_q;
  logic          flash_dark_q;
  logic          fault_q;
  logic [1:0]    err_q;

  logic          legal_c;
  logic          step_ok_c;
  logic [CW-1:0] min_dwell_c;
  logic [1:0]    check_c;

  // Change checks in priority order: encoding, sequence, then dwell of the old colour.
  always_comb begin
    legal_c     = (bus.lights == RED) || (bus.lights == YEL) || (bus.lights == GRN);
    step_ok_c   = ((lights_q == RED) && (bus.lights == GRN)) ||
                  ((lights_q == GRN) && (bus.lights == YEL)) ||
                  ((lights_q == YEL) && (bus.lights == RED));
    min_dwell_c = '0;
    case (lights_q)
      RED:     min_dwell_c = CW'(MIN_RED);
      GRN:     min_dwell_c = CW'(MIN_GREEN);
      YEL:     min_dwell_c = CW'(MIN_YELLOW);
      default: min_dwell_c = '0;
    endcase
    check_c = ERR_NONE;
    if (!legal_c)                                       check_c = ERR_ENC;
    else if (!step_ok_c)                                check_c = ERR_TRANS;
    else if (!first_seg_q && (dwell_q < min_dwell_c))   check_c = ERR_DWELL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_INIT;
      lights_q     <= RED;
      lamp_q       <= RED;
      dwell_q      <= '0;
      flash_q      <= '0;
      cycle_q      <= '0;
      first_seg_q  <= 1'b1;
      flash_dark_q <= 1'b0;
      fault_q      <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      case (state)
        S_INIT: begin
          if (legal_c) begin
            state       <= S_RUN;
            lights_q    <= bus.lights;
            lamp_q      <= bus.lights;
            dwell_q     <= CW'(1);
            first_seg_q <= 1'b1;
          end else begin
            lamp_q <= RED;
          end
        end
        S_RUN: begin
          if (bus.lights == lights_q) begin
            if (dwell_q != DWELL_MAX) dwell_q <= dwell_q + CW'(1);
          end else if (check_c != ERR_NONE) begin
            state        <= S_FAULT;
            fault_q      <= 1'b1;
            err_q        <= check_c;
            flash_q      <= '0;
            flash_dark_q <= 1'b0;
            lamp_q       <= RED;
          end else begin
            lights_q    <= bus.lights;
            lamp_q      <= bus.lights;
            dwell_q     <= CW'(1);
            first_seg_q <= 1'b0;
            if (lights_q == RED) cycle_q <= cycle_q + CW'(1);
          end
        end
        S_FAULT: begin
          if (bus.clear_fault) begin
            state        <= S_INIT;
            fault_q      <= 1'b0;
            err_q        <= ERR_NONE;
            flash_q      <= '0;
            flash_dark_q <= 1'b0;
            lamp_q       <= RED;
          end else if (flash_q == HALF_LAST) begin
            flash_q      <= '0;
            flash_dark_q <= ~flash_dark_q;
            lamp_q       <= flash_dark_q ? RED : DARK;
          end else begin
            flash_q <= flash_q + CW'(1);
            lamp_q  <= flash_dark_q ? DARK : RED;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.lamp_out    = lamp_q;
  assign bus.fault       = fault_q;
  assign bus.err_code    = err_q;
  assign bus.cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random light streams,
// checked every cycle against a colour/run-length model of the monitor rules.
`timescale 1ns/1ps
module tb_traffic_light_monitor;
  localparam int unsigned MIN_R = 4;
  localparam int unsigned MIN_G = 4;
  localparam int unsigned MIN_Y = 2;
  localparam int unsigned HALF  = 3;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  traffic_light_monitor_if bus();

  traffic_light_monitor #(
    .MIN_RED(MIN_R), .MIN_GREEN(MIN_G), .MIN_YELLOW(MIN_Y), .FLASH_HALF(HALF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = waiting for first legal colour, 1 = running, 2 = faulted.
  int         m_mode  = 0;
  logic [2:0] m_col   = R;
  int         m_len   = 0;
  bit         m_first = 1'b1;
  int         m_cnt   = 0;
  int         m_err   = 0;
  int         m_age   = 0;
  int         m_code  = 0;

  function automatic bit is_legal(input logic [2:0] l);
    return (l == R) || (l == Y) || (l == G);
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] c);
    return (c == R) ? G : (c == G) ? Y : R;
  endfunction

  function automatic int min_for(input logic [2:0] c);
    return (c == R) ? MIN_R : (c == G) ? MIN_G : MIN_Y;
  endfunction

  function automatic logic [2:0] exp_lamp();
    if (m_mode == 0) return R;
    if (m_mode == 1) return m_col;
    return (((m_age / HALF) % 2) == 0) ? R : 3'b000;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_col = R; m_len = 0; m_first = 1'b1;
      m_cnt = 0; m_err = 0; m_age = 0;
    end else begin
      case (m_mode)
        0: if (is_legal(bus.lights)) begin
             m_mode = 1; m_col = bus.lights; m_len = 1; m_first = 1'b1;
           end
        1: if (bus.lights == m_col) begin
             if (m_len < 65535) m_len++;
           end else begin
             m_code = !is_legal(bus.lights)          ? 1 :
                      (bus.lights != succ(m_col))    ? 2 :
                      (!m_first && m_len < min_for(m_col)) ? 3 : 0;
             if (m_code != 0) begin
               m_mode = 2; m_err = m_code; m_age = 0;
             end else begin
               if (m_col == R) m_cnt = (m_cnt + 1) % 65536;
               m_col = bus.lights; m_len = 1; m_first = 1'b0;
             end
           end
        default: if (bus.clear_fault) begin
                   m_mode = 0; m_err = 0;
                 end else begin
                   m_age++;
                 end
      endcase
    end
  end

  // Every-cycle comparison against the model, half a period after the edge.
  always @(negedge clk) begin
    chk("lamp_out",    32'(bus.lamp_out),    32'(exp_lamp()));
    chk("fault",       32'(bus.fault),       32'(m_mode == 2));
    chk("err_code",    32'(bus.err_code),    m_err);
    chk("cycle_count", 32'(bus.cycle_count), m_cnt);
  end

  task automatic step(input logic [2:0] l, input logic clr = 1'b0);
    bus.lights = l;
    bus.clear_fault = clr;
    @(posedge clk);
    #1;
    bus.clear_fault = 1'b0;
  endtask

  task automatic hold(input logic [2:0] l, input int n);
    repeat (n) step(l);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  logic [2:0] flash_exp [6];
  logic [2:0] legal_set [3];
  logic [2:0] gcol;
  logic [2:0] l;
  int         left;
  int         r;

  initial begin
    flash_exp = '{R, R, 3'b000, 3'b000, 3'b000, R};
    legal_set = '{R, Y, G};
    bus.lights = 3'b000;
    bus.clear_fault = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("reset_lamp",  32'(bus.lamp_out),    32'h4);
    chk("reset_fault", 32'(bus.fault),       32'h0);
    chk("reset_err",   32'(bus.err_code),    32'h0);
    chk("reset_count", 32'(bus.cycle_count), 32'h0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // Illegal values before the first legal colour are ignored.
    hold(3'b110, 2);
    chk("init_illegal_fault", 32'(bus.fault),    32'h0);
    chk("init_illegal_lamp",  32'(bus.lamp_out), 32'h4);

    // Three legal R/G/Y cycles.
    for (int rep = 0; rep < 3; rep++) begin
      hold(R, 4);
      step(G);
      if (rep == 0) chk("lamp_lag_green", 32'(bus.lamp_out), 32'h1);
      hold(G, 3);
      hold(Y, 2);
    end
    step(R);
    chk("legal_cycle_count", 32'(bus.cycle_count), 32'd3);
    chk("legal_cycle_fault", 32'(bus.fault),       32'h0);

    // Short yellow, then the red flash sequence.
    do_reset();
    hold(R, 4);
    hold(G, 4);
    step(Y);
    step(R);
    chk("short_y_fault", 32'(bus.fault),    32'h1);
    chk("short_y_err",   32'(bus.err_code), 32'h3);
    chk("short_y_lamp0", 32'(bus.lamp_out), 32'h4);
    for (int i = 0; i < 6; i++) begin
      step(R);
      chk("flash_lamp", 32'(bus.lamp_out), 32'(flash_exp[i]));
    end
    step(3'b110);
    chk("sticky_err_dwell", 32'(bus.err_code), 32'h3);

    // Clear wins over an illegal value; next legal colour restarts without dwell check.
    step(3'b011, 1'b1);
    chk("clear_fault",  32'(bus.fault),       32'h0);
    chk("clear_err",    32'(bus.err_code),    32'h0);
    chk("clear_lamp",   32'(bus.lamp_out),    32'h4);
    chk("clear_count",  32'(bus.cycle_count), 32'd1);
    step(G);
    chk("recover_lamp",  32'(bus.lamp_out), 32'h1);
    chk("recover_fault", 32'(bus.fault),    32'h0);
    hold(G, 3);
    hold(Y, 2);
    step(R);
    chk("recover_run_fault", 32'(bus.fault), 32'h0);

    // Illegal transition R->Y, sticky under a later bad encoding.
    do_reset();
    hold(R, 4);
    step(Y);
    chk("bad_trans_err", 32'(bus.err_code), 32'h2);
    step(3'b111);
    chk("sticky_err_trans", 32'(bus.err_code), 32'h2);

    // Illegal encoding in RUN, then asynchronous reset while faulted.
    do_reset();
    hold(R, 4);
    hold(G, 2);
    step(3'b110);
    chk("bad_enc_err", 32'(bus.err_code), 32'h1);
    step(3'b111);
    chk("sticky_err_enc", 32'(bus.err_code), 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("async_fault", 32'(bus.fault),       32'h0);
    chk("async_err",   32'(bus.err_code),    32'h0);
    chk("async_count", 32'(bus.cycle_count), 32'h0);
    chk("async_lamp",  32'(bus.lamp_out),    32'h4);
    reset = 1'b1;

    // Counter wrap from 0xFFFF.
    hold(R, 4);
    #1;
    force dut.cycle_q = 16'hFFFF;
    m_cnt = 65535;
    #1;
    release dut.cycle_q;
    step(G);
    chk("wrap_count", 32'(bus.cycle_count), 32'h0);
    chk("wrap_fault", 32'(bus.fault),       32'h0);

    // Random light streams with occasional glitches, clears and resets.
    gcol = R;
    left = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (left == 0) begin
        gcol = ($urandom_range(0, 9) == 0) ? legal_set[$urandom_range(0, 2)] : succ(gcol);
        left = int'($urandom_range(1, 6));
      end
      left--;
      l = (r < 40) ? 3'($urandom) : gcol;
      if (r < 3) begin
        reset = 1'b0;
        step(l);
        reset = 1'b1;
      end else begin
        step(l, r >= 950);
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have parameter MIN_RED, default 4, giving the minimum legal red dwell in clock cycles.
REQ-002 The block SHALL have parameter MIN_GREEN, default 4, giving the minimum legal green dwell in clock cycles.
REQ-003 The block SHALL have parameter MIN_YELLOW, default 2, giving the minimum legal yellow dwell in clock cycles.
REQ-004 The block SHALL have parameter FLASH_HALF, default 3, giving the half-period of the fault red-flash in clock cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port lights, input, 3 bits: light pattern from the upstream traffic-light FSM, where bit2 = R, bit1 = Y and bit0 = G.
REQ-008 The block SHALL have port clear_fault, input, 1 bit: a synchronous one-cycle pulse that leaves the FAULT state.
REQ-009 The block SHALL have port lamp_out, output, 3 bits: the lamp-driver pattern, same RYG bit order as lights.
REQ-010 The block SHALL have port fault, output, 1 bit: high while the block is in the FAULT state.
REQ-011 The block SHALL have port err_code, output, 2 bits: 00 none, 01 illegal encoding, 10 illegal transition, 11 dwell too short.
REQ-012 The block SHALL have port cycle_count, output, 16 bits: count of completed R->G transitions.

Function
REQ-013 The block SHALL implement the states INIT, RUN and FAULT, and SHALL enter INIT on reset.
REQ-014 Legal values SHALL be the one-hot patterns 100 (R), 010 (Y) and 001 (G); every other value SHALL be illegal encoding.
REQ-015 In INIT, on the first rising edge where lights is legal, the block SHALL enter RUN, latch the value into lights_q, set dwell to 1 and skip the dwell check for that first segment.
REQ-016 In INIT, an illegal lights value SHALL be ignored: no fault, and lamp_out = 100 (solid red).
REQ-017 In RUN, when lights equals lights_q at an edge, dwell SHALL increment, saturating at 0xFFFF.
REQ-018 In RUN, when lights differs from lights_q at an edge, the block SHALL perform the following checks in priority order:
  - illegal encoding -> err_code 01;
  - transition other than R->G, G->Y or Y->R -> err_code 10;
  - dwell of the old colour below its MIN_* parameter, and the old segment is not the first segment -> err_code 11;
  - otherwise the block SHALL accept the change: lights_q <= lights, dwell <= 1.
REQ-019 Any check failure SHALL move the block to FAULT at that edge, so fault is high and err_code is valid from the same edge onward.
REQ-020 err_code SHALL hold the first fault's code (sticky) until a reset or clear_fault.
REQ-021 In RUN, lamp_out SHALL equal lights_q, giving one cycle of latency from lights.
REQ-022 Each accepted R->G transition SHALL increment cycle_count at that edge, wrapping from 0xFFFF to 0x0000.
REQ-023 In FAULT, lamp_out SHALL flash red:
  - it SHALL be 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating;
  - the first 100 phase SHALL start at the fault edge.
REQ-024 In FAULT, the lights input SHALL be ignored and cycle_count SHALL hold.
REQ-025 When clear_fault = 1 in FAULT, the block SHALL enter INIT and clear fault, err_code and the flash counter, while cycle_count is preserved.
REQ-026 When clear_fault = 1 in INIT or RUN, it SHALL have no effect.
REQ-027 When clear_fault is asserted in FAULT at the same edge that lights is illegal, clear SHALL win: the block enters INIT and no new fault is raised.
REQ-028 The dwell and flash counters SHALL be 16 bits wide, and FLASH_HALF = 0 SHALL be treated as 1.

Reset
REQ-029 When reset = 0, the block SHALL immediately (asynchronously) force:
  - state INIT, lamp_out = 100, fault = 0, err_code = 00;
  - cycle_count = 0, dwell = 0, lights_q = 100, flash counter = 0.
REQ-030 Reset asserted mid-operation, including in FAULT, SHALL override all other inputs.
REQ-031 After reset release, the first rising edge SHALL be evaluated under the INIT rules.

Verification
REQ-032 Legal cycle (defaults): hold R 4 cycles, then G 4, then Y 2, then R, repeated 3 times -> fault stays 0, lamp_out follows lights with one cycle of lag, and cycle_count ends at 3.
REQ-033 Short yellow: in RUN, after R 4 and G 4, hold Y for 1 cycle and then present R -> fault = 1 with err_code 11 at that edge, and lamp_out = 100,100,100,000,000,000,100...
REQ-034 Illegal encoding and transition:
  - lights = 110 in RUN -> err_code 01;
  - after a reset, R 4 then Y -> err_code 10;
  - err_code stays sticky when further bad values follow.
REQ-035 Clear and recovery: in FAULT, pulse clear_fault while lights = 011 -> the block enters INIT, fault = 0, cycle_count is unchanged; a following legal G is accepted without a dwell check.
REQ-036 Wrap: preload cycle_count by running 65535 legal cycles (or force it), then do one more R->G -> cycle_count = 0x0000 and fault = 0.
REQ-037 Asynchronous reset: drop reset mid-cycle during FAULT -> fault, err_code and cycle_count read 0 and lamp_out reads 100 before the next clock edge.
